// File: rtl/spi_pkg.sv
// Shared definitions for the SPI target endpoint: mode constants, FSM states
// and the bit-counter width helper.
package spi_pkg;

  localparam logic CPOL0      = 1'b0;
  localparam logic CPOL1      = 1'b1;
  localparam logic SAMPLE_1ST = 1'b0;
  localparam logic SAMPLE_2ND = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Counter must hold the values 0..bits.
  function automatic int unsigned cnt_width(input int unsigned bits);
    return $clog2(bits + 1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-stage synchronizer plus history flop for one asynchronous pin.
// Provides the synchronized level and single-cycle rise/fall strobes.
module spi_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic ff1;
  logic ff2;
  logic hist;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ff1  <= RST_VAL;
      ff2  <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      ff1  <= din;
      ff2  <= ff1;
      hist <= ff2;
    end
  end

  assign level = ff2;
  assign rise  = ff2 & ~hist;
  assign fall  = ~ff2 & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI target endpoint: oversamples sck/cs/sdi in the clk domain, receives one
// BITS-wide word per chip-select frame and returns a preloaded word on sdo.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter logic        SCKINT = CPOL0,
  parameter logic        SPEDGE = SAMPLE_1ST
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] dataOut,
  output logic [BITS-1:0] dataIn,
  output logic            valid,
  output logic            abort,
  output logic            working,
  output logic            sdo_oe,
  input  logic            sck,
  input  logic            cs,
  input  logic            sdi,
  output logic            sdo
);

  localparam int unsigned CW = cnt_width(BITS);

  logic sck_level;
  logic sck_rise;
  logic sck_fall;
  logic cs_level;
  logic cs_rise;
  logic cs_fall;
  logic [1:0] sdi_ff;

  state_t          state;
  logic [BITS-1:0] tx;
  logic [BITS-1:0] rx;
  logic [CW-1:0]   cnt;

  logic sck_edge;
  logic lead;
  logic trail;
  logic sample;
  logic shift;
  logic last;

  spi_sync_edge #(.RST_VAL(SCKINT)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  // Resetting to "low" means a cs held low through reset never shows a fall,
  // so a frame in flight is ignored until cs has been seen high again.
  spi_sync_edge #(.RST_VAL(1'b0)) u_cs_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (cs),
    .level (cs_level),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Same two-stage depth as sck keeps data aligned with its clock edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sdi_ff <= '0;
    end else begin
      sdi_ff <= {sdi_ff[0], sdi};
    end
  end

  assign sck_edge = sck_rise | sck_fall;
  assign lead     = sck_edge & (sck_level != SCKINT);
  assign trail    = sck_edge & (sck_level == SCKINT);
  assign sample   = SPEDGE ? trail : lead;
  assign shift    = SPEDGE ? lead : trail;
  assign last     = sample & (cnt == CW'(BITS - 1));

  // Frame FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= '0;
      rx      <= '0;
      cnt     <= '0;
      dataIn  <= '0;
      valid   <= 1'b0;
      abort   <= 1'b0;
      working <= 1'b0;
      sdo_oe  <= 1'b0;
      sdo     <= 1'b0;
    end else begin
      valid <= 1'b0;
      abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state   <= ACTIVE;
            rx      <= '0;
            cnt     <= '0;
            working <= 1'b1;
            sdo_oe  <= 1'b1;
            if (SPEDGE) begin
              tx  <= dataOut;
              sdo <= 1'b0;
            end else begin
              tx  <= {dataOut[BITS-2:0], 1'b0};
              sdo <= dataOut[BITS-1];
            end
          end
        end
        ACTIVE: begin
          if (last) begin
            // Final sample beats a simultaneous cs rise.
            dataIn <= {rx[BITS-2:0], sdi_ff[1]};
            rx     <= {rx[BITS-2:0], sdi_ff[1]};
            cnt    <= cnt + CW'(1);
            valid  <= 1'b1;
            sdo    <= 1'b0;
            if (cs_rise) begin
              state   <= IDLE;
              working <= 1'b0;
              sdo_oe  <= 1'b0;
            end else begin
              state <= DONE;
            end
          end else if (cs_rise) begin
            state   <= IDLE;
            abort   <= 1'b1;
            working <= 1'b0;
            sdo_oe  <= 1'b0;
            sdo     <= 1'b0;
          end else begin
            if (sample) begin
              rx  <= {rx[BITS-2:0], sdi_ff[1]};
              cnt <= cnt + CW'(1);
            end
            if (shift) begin
              sdo <= tx[BITS-1];
              tx  <= {tx[BITS-2:0], 1'b0};
            end
          end
        end
        DONE: begin
          sdo <= 1'b0;
          if (cs_level) begin
            state   <= IDLE;
            working <= 1'b0;
            sdo_oe  <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          working <= 1'b0;
          sdo_oe  <= 1'b0;
          sdo     <= 1'b0;
        end
      endcase
    end
  end

endmodule
